control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter XLEN, default 64: datapath width of operands and result.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk, input, 1: rising-edge clock; all outputs are registered on it.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port instr, input, 32: instruction word; opcode=instr[6:0], func3=instr[14:12], func7 bit=instr[30].
REQ-006 Port rs1_data, input, XLEN: ALU source 1.
REQ-007 Port rs2_data, input, XLEN: register source 2.
REQ-008 Port imm, input, XLEN: sign-extended immediate.
REQ-009 Ports ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, output, 1 each: datapath control strobes.
REQ-010 Port ALUOp, output, 2: ALU operation class.
REQ-011 Port alu_code, output, 4: decoded ALU operation.
REQ-012 Port result, output, XLEN: ALU result.
REQ-013 Ports zero and overflow, output, 1 each: ALU flags.

Function
REQ-014 Timing: inputs are sampled on each rising clk edge; all outputs reflect those inputs after that edge (latency 1 cycle); no handshake; a new instruction is accepted every cycle.
REQ-015 Main decode, control bits listed as ALUSrc/MemtoReg/RegWrite/MemRead/MemWrite/Branch then ALUOp:
- 0110011 (R-type): 0/0/1/0/0/0, ALUOp 10.
- 0010011 (I-arith): 1/0/1/0/0/0, ALUOp 11.
- 0000011 (load): 1/1/1/1/0/0, ALUOp 00.
- 0100011 (store): 1/0/0/0/1/0, ALUOp 00.
- 1100011 (branch): 0/0/0/0/0/1, ALUOp 01.
- Any other opcode: all strobes 0, ALUOp 00.
REQ-016 ALU control codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001.
REQ-017 ALU control decode by ALUOp:
- ALUOp 00: ADD.
- ALUOp 01: SUB.
- ALUOp 10: decode by func3. 000 gives ADD, or SUB when instr[30]=1. 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, or SRA when instr[30]=1. 110 OR, 111 AND.
- ALUOp 11: same func3 decode as ALUOp 10, except func3=000 is always ADD (instr[30] ignored).
REQ-018 Operand 2 is imm when ALUSrc=1, otherwise rs2_data.
REQ-019 Arithmetic: ADD/SUB wrap modulo 2^XLEN. Shift amount is operand2[5:0]. SRA is arithmetic. SLT is signed compare and SLTU unsigned compare, each giving result 1 or 0. Codes 1010-1111 give result 0.
REQ-020 zero=1 exactly when result==0, for every code.
REQ-021 overflow=1 only for ADD/SUB two's-complement signed overflow; it is 0 for all other codes.
REQ-022 result, zero, overflow and alu_code SHALL be computed from the same sampled instruction as the control strobes; no mixing across cycles.

Reset
REQ-023 While rst_n=0, all outputs are 0 (result 0, zero 0, overflow 0, ALUOp 00, alu_code 0000), asynchronously and irrespective of clk.
REQ-024 Reset deasserted: the first rising edge with rst_n=1 loads the decode of the current inputs; reset asserted mid-stream discards the in-flight result.

Verification
REQ-025 R-type ADD with instr=0x002081B3, rs1_data=5, rs2_data=7 -> after 1 edge: RegWrite=1, ALUOp=10, alu_code=0010, result=12, zero=0.
REQ-026 R-type SUB with instr=0x402081B3, rs1_data=rs2_data=0x7FFFFFFFFFFFFFFF -> alu_code=0110, result=0, zero=1, overflow=0.
REQ-027 Load with instr=0x0000B103 (ld), rs1_data=0x100, imm=8 -> ALUSrc=MemtoReg=RegWrite=MemRead=1, ALUOp=00, result=0x108.
REQ-028 Branch (beq) with rs1_data=rs2_data=3 -> Branch=1, ALUOp=01, alu_code=0110, zero=1. Store (sd) -> MemWrite=1, RegWrite=0.
REQ-029 ADD with rs1_data=0x7FFFFFFFFFFFFFFF, rs2_data=1 -> result=0x8000000000000000, overflow=1.
REQ-030 Unknown opcode 0x7F -> all strobes 0. Assert rst_n=0 between clock edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/control_unit.sv
// Single-cycle RV64-style main decoder, ALU control decoder and ALU.
// Every output is registered once, so strobes, ALU code and ALU result always belong to the same instruction.
module control_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            ALUSrc,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            Branch,
    output logic [1:0]      ALUOp,
    output logic [3:0]      alu_code,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow
);

    typedef enum logic [6:0] {
        OP_RTYPE  = 7'b0110011,
        OP_IARITH = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_IARITH = 2'b11
    } aluop_e;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_code_e;

    typedef struct packed {
        logic   alusrc;
        logic   memtoreg;
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   branch;
        aluop_e aluop;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7b5;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign func3             = instr[14:12];
    assign func7b5           = instr[30];
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    ctrl_t           ctrl_d,     ctrl_q;
    alu_code_e       code_d,     code_q;
    logic [XLEN-1:0] result_d,   result_q;
    logic            zero_d,     zero_q;
    logic            overflow_d, overflow_q;

    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [5:0]      shamt;

    // Main decoder
    always_comb begin
        ctrl_d = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluop    = ALUOP_RTYPE;
            end
            OP_IARITH: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.aluop    = ALUOP_IARITH;
            end
            OP_LOAD: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memtoreg = 1'b1;
                ctrl_d.regwrite = 1'b1;
                ctrl_d.memread  = 1'b1;
                ctrl_d.aluop    = ALUOP_MEM;
            end
            OP_STORE: begin
                ctrl_d.alusrc   = 1'b1;
                ctrl_d.memwrite = 1'b1;
                ctrl_d.aluop    = ALUOP_MEM;
            end
            OP_BRANCH: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.aluop    = ALUOP_BRANCH;
            end
            default: ctrl_d = '0;
        endcase
    end

    // ALU control; I-arith shares the func3 table but has no SUB form
    always_comb begin
        code_d = ALU_ADD;
        case (ctrl_d.aluop)
            ALUOP_MEM:    code_d = ALU_ADD;
            ALUOP_BRANCH: code_d = ALU_SUB;
            default: begin
                case (func3)
                    3'b000: code_d = (func7b5 && ctrl_d.aluop == ALUOP_RTYPE) ? ALU_SUB : ALU_ADD;
                    3'b001: code_d = ALU_SLL;
                    3'b010: code_d = ALU_SLT;
                    3'b011: code_d = ALU_SLTU;
                    3'b100: code_d = ALU_XOR;
                    3'b101: code_d = func7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: code_d = ALU_OR;
                    default: code_d = ALU_AND;
                endcase
            end
        endcase
    end

    assign op_b  = ctrl_d.alusrc ? imm : rs2_data;
    assign sum   = rs1_data + op_b;
    assign diff  = rs1_data - op_b;
    assign shamt = op_b[5:0];

    // Signed overflow: operands agree (ADD) or differ (SUB) in sign and the result sign flips
    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        case (code_d)
            ALU_AND: result_d = rs1_data & op_b;
            ALU_OR:  result_d = rs1_data | op_b;
            ALU_XOR: result_d = rs1_data ^ op_b;
            ALU_ADD: begin
                result_d   = sum;
                overflow_d = (rs1_data[XLEN-1] == op_b[XLEN-1]) &&
                             (sum[XLEN-1] != rs1_data[XLEN-1]);
            end
            ALU_SUB: begin
                result_d   = diff;
                overflow_d = (rs1_data[XLEN-1] != op_b[XLEN-1]) &&
                             (diff[XLEN-1] != rs1_data[XLEN-1]);
            end
            ALU_SLL:  result_d = rs1_data << shamt;
            ALU_SRL:  result_d = rs1_data >> shamt;
            ALU_SRA:  result_d = $signed(rs1_data) >>> shamt;
            ALU_SLT:  result_d = {{(XLEN-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
            ALU_SLTU: result_d = {{(XLEN-1){1'b0}}, (rs1_data < op_b)};
            default:  result_d = '0;
        endcase
    end

    assign zero_d = (result_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            code_q     <= ALU_AND;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            code_q     <= code_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign ALUSrc   = ctrl_q.alusrc;
    assign MemtoReg = ctrl_q.memtoreg;
    assign RegWrite = ctrl_q.regwrite;
    assign MemRead  = ctrl_q.memread;
    assign MemWrite = ctrl_q.memwrite;
    assign Branch   = ctrl_q.branch;
    assign ALUOp    = ctrl_q.aluop;
    assign alu_code = code_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected outputs are queued when inputs are driven
// and compared one cycle later against the registered outputs.
module tb_control_unit;

    localparam int unsigned XLEN = 64;

    typedef struct packed {
        logic [5:0]      strobes;   // ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch
        logic [1:0]      aluop;
        logic [3:0]      code;
        logic [XLEN-1:0] result;
        logic            zero;
        logic            ovf;
    } out_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     instr = '0;
    logic [XLEN-1:0] rs1_data = '0;
    logic [XLEN-1:0] rs2_data = '0;
    logic [XLEN-1:0] imm = '0;
    logic            ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0]      ALUOp;
    logic [3:0]      alu_code;
    logic [XLEN-1:0] result;
    logic            zero, overflow;

    int unsigned tests_run = 0;
    int unsigned failed = 0;
    out_t        sb[$];

    control_unit #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .imm      (imm),
        .ALUSrc   (ALUSrc),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ALUOp    (ALUOp),
        .alu_code (alu_code),
        .result   (result),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1);
    end

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic b30);
        return {1'b0, b30, 5'd0, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference model written from the decode and ALU tables
    function automatic out_t model(input logic [31:0] ins, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b2, input logic [XLEN-1:0] im);
        out_t            o;
        logic [7:0]      c;
        logic [XLEN-1:0] b;
        logic [XLEN:0]   wide;
        o = '0;
        case (ins[6:0])
            7'h33:   c = 8'b001000_10;
            7'h13:   c = 8'b101000_11;
            7'h03:   c = 8'b111100_00;
            7'h23:   c = 8'b100010_00;
            7'h63:   c = 8'b000001_01;
            default: c = 8'b000000_00;
        endcase
        o.strobes = c[7:2];
        o.aluop   = c[1:0];
        b = c[7] ? im : b2;
        if (c[1:0] == 2'b00)      o.code = 4'd2;
        else if (c[1:0] == 2'b01) o.code = 4'd6;
        else begin
            case (ins[14:12])
                3'd0: o.code = (c[1:0] == 2'b10 && ins[30]) ? 4'd6 : 4'd2;
                3'd1: o.code = 4'd4;
                3'd2: o.code = 4'd8;
                3'd3: o.code = 4'd9;
                3'd4: o.code = 4'd3;
                3'd5: o.code = ins[30] ? 4'd7 : 4'd5;
                3'd6: o.code = 4'd1;
                default: o.code = 4'd0;
            endcase
        end
        case (o.code)
            4'd0: o.result = a & b;
            4'd1: o.result = a | b;
            4'd2: begin
                wide = {a[XLEN-1], a} + {b[XLEN-1], b};
                o.result = wide[XLEN-1:0];
                o.ovf = wide[XLEN] ^ wide[XLEN-1];
            end
            4'd3: o.result = a ^ b;
            4'd4: o.result = a << b[5:0];
            4'd5: o.result = a >> b[5:0];
            4'd6: begin
                wide = {a[XLEN-1], a} - {b[XLEN-1], b};
                o.result = wide[XLEN-1:0];
                o.ovf = wide[XLEN] ^ wide[XLEN-1];
            end
            4'd7: o.result = $signed(a) >>> b[5:0];
            4'd8: o.result = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9: o.result = (a < b) ? 64'd1 : 64'd0;
            default: o.result = '0;
        endcase
        o.zero = (o.result == 0);
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.strobes = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch};
        o.aluop   = ALUOp;
        o.code    = alu_code;
        o.result  = result;
        o.zero    = zero;
        o.ovf     = overflow;
        return o;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] im);
        instr    = ins;
        rs1_data = a;
        rs2_data = b;
        imm      = im;
        sb.push_back(model(ins, a, b, im));
    endtask

    task automatic test_reset();
        out_t obs, exp;
        rst_n = 1'b0;
        instr = 32'h002081B3; rs1_data = 64'd5; rs2_data = 64'd7; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        obs = sample();
        tests_run++;
        if (obs !== '0) begin failed++; $display("FAIL reset_hold: got %h expected 0", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h002081B3, 64'd5, 64'd7, 64'd0);
        @(posedge clk); #1;
        obs = sample();
        tests_run++;
        if (sb.size() == 0) begin failed++; $display("FAIL reset_first_edge: scoreboard empty"); end
        else begin
            exp = sb.pop_front();
            if (obs !== exp) begin failed++; $display("FAIL reset_first_edge: got %h expected %h", obs, exp); end
        end
    endtask

    task automatic test_rtype();
        out_t obs, exp;
        @(negedge clk);
        drive(32'h002081B3, 64'd5, 64'd7, 64'hDEAD);
        @(posedge clk); #1;
        obs = sample();
        tests_run++;
        if (RegWrite !== 1'b1 || ALUOp !== 2'b10 || alu_code !== 4'b0010 || result !== 64'd12 || zero !== 1'b0) begin
            failed++;
            $display("FAIL rtype_add_direct: got rw=%b aluop=%b code=%b result=%0d zero=%b expected 1 10 0010 12 0", RegWrite, ALUOp, alu_code, result, zero);
        end
        void'(sb.pop_front());
        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < 2; s++) begin
                @(negedge clk);
                drive(mk(7'h33, 3'(f), 1'(s)), rnd64(), rnd64(), rnd64());
                @(posedge clk); #1;
                obs = sample();
                tests_run++;
                if (sb.size() == 0) begin failed++; $display("FAIL rtype_f3_%0d_b30_%0d: scoreboard empty", f, s); end
                else begin
                    exp = sb.pop_front();
                    if (obs !== exp) begin failed++; $display("FAIL rtype_f3_%0d_b30_%0d: got %h expected %h", f, s, obs, exp); end
                end
            end
        end
    endtask

    task automatic test_iarith();
        out_t obs, exp;
        for (int f = 0; f < 8; f++) begin
            for (int s = 0; s < 2; s++) begin
                @(negedge clk);
                drive(mk(7'h13, 3'(f), 1'(s)), rnd64(), rnd64(), rnd64());
                @(posedge clk); #1;
                obs = sample();
                tests_run++;
                if (sb.size() == 0) begin failed++; $display("FAIL iarith_f3_%0d_b30_%0d: scoreboard empty", f, s); end
                else begin
                    exp = sb.pop_front();
                    if (obs !== exp) begin failed++; $display("FAIL iarith_f3_%0d_b30_%0d: got %h expected %h", f, s, obs, exp); end
                end
            end
        end
        @(negedge clk);
        drive(mk(7'h13, 3'd0, 1'b1), 64'd10, 64'd99, 64'd3);
        @(posedge clk); #1;
        tests_run++;
        if (alu_code !== 4'b0010 || result !== 64'd13 || ALUSrc !== 1'b1 || ALUOp !== 2'b11) begin
            failed++;
            $display("FAIL iarith_addi_b30: got code=%b result=%0d alusrc=%b aluop=%b expected 0010 13 1 11", alu_code, result, ALUSrc, ALUOp);
        end
        void'(sb.pop_front());
    endtask

    task automatic test_load_store();
        out_t obs, exp;
        @(negedge clk);
        drive(32'h0000B103, 64'h100, 64'h5555, 64'd8);
        @(posedge clk); #1;
        obs = sample();
        tests_run++;
        if (obs.strobes !== 6'b111100 || ALUOp !== 2'b00 || result !== 64'h108) begin
            failed++;
            $display("FAIL load_ld: got strobes=%b aluop=%b result=%h expected 111100 00 108", obs.strobes, ALUOp, result);
        end
        void'(sb.pop_front());
        @(negedge clk);
        drive(32'h0020B023, 64'h2000, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF8);
        @(posedge clk); #1;
        obs = sample();
        tests_run++;
        if (MemWrite !== 1'b1 || RegWrite !== 1'b0 || result !== 64'h1FF8) begin
            failed++;
            $display("FAIL store_sd: got memwrite=%b regwrite=%b result=%h expected 1 0 1ff8", MemWrite, RegWrite, result);
        end
        tests_run++;
        if (sb.size() == 0) begin failed++; $display("FAIL store_sd_model: scoreboard empty"); end
        else begin
            exp = sb.pop_front();
            if (obs !== exp) begin failed++; $display("FAIL store_sd_model: got %h expected %h", obs, exp); end
        end
    endtask

    task automatic test_branch();
        out_t obs, exp;
        @(negedge clk);
        drive(32'h00208063, 64'd3, 64'd3, 64'd77);
        @(posedge clk); #1;
        tests_run++;
        if (Branch !== 1'b1 || ALUOp !== 2'b01 || alu_code !== 4'b0110 || zero !== 1'b1 || RegWrite !== 1'b0) begin
            failed++;
            $display("FAIL branch_beq_eq: got br=%b aluop=%b code=%b zero=%b rw=%b expected 1 01 0110 1 0", Branch, ALUOp, alu_code, zero, RegWrite);
        end
        void'(sb.pop_front());
        @(negedge clk);
        drive(32'h00208063, 64'd3, 64'd4, 64'd0);
        @(posedge clk); #1;
        obs = sample();
        tests_run++;
        if (sb.size() == 0) begin failed++; $display("FAIL branch_beq_ne: scoreboard empty"); end
        else begin
            exp = sb.pop_front();
            if (obs !== exp) begin failed++; $display("FAIL branch_beq_ne: got %h expected %h", obs, exp); end
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        drive(32'h002081B3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        @(posedge clk); #1;
        tests_run++;
        if (result !== 64'h8000_0000_0000_0000 || overflow !== 1'b1 || zero !== 1'b0) begin
            failed++;
            $display("FAIL add_overflow: got result=%h ovf=%b zero=%b expected 8000000000000000 1 0", result, overflow, zero);
        end
        void'(sb.pop_front());
        @(negedge clk);
        drive(32'h402081B3, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        @(posedge clk); #1;
        tests_run++;
        if (alu_code !== 4'b0110 || result !== 64'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
            failed++;
            $display("FAIL sub_equal_max: got code=%b result=%h zero=%b ovf=%b expected 0110 0 1 0", alu_code, result, zero, overflow);
        end
        void'(sb.pop_front());
        @(negedge clk);
        drive(32'h402081B3, 64'h8000_0000_0000_0000, 64'd1, 64'd0);
        @(posedge clk); #1;
        tests_run++;
        if (result !== 64'h7FFF_FFFF_FFFF_FFFF || overflow !== 1'b1) begin
            failed++;
            $display("FAIL sub_overflow: got result=%h ovf=%b expected 7fffffffffffffff 1", result, overflow);
        end
        void'(sb.pop_front());
        @(negedge clk);
        drive(mk(7'h33, 3'd6, 1'b0), 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
        @(posedge clk); #1;
        tests_run++;
        if (overflow !== 1'b0 || result !== 64'h7FFF_FFFF_FFFF_FFFF) begin
            failed++;
            $display("FAIL or_no_overflow: got result=%h ovf=%b expected 7fffffffffffffff 0", result, overflow);
        end
        void'(sb.pop_front());
    endtask

    task automatic test_unknown();
        out_t obs;
        @(negedge clk);
        drive(32'h0000007F, 64'd9, 64'd4, 64'd1);
        @(posedge clk); #1;
        obs = sample();
        tests_run++;
        if (obs.strobes !== 6'b0 || obs.aluop !== 2'b00 || obs.code !== 4'b0010 || obs.result !== 64'd13) begin
            failed++;
            $display("FAIL unknown_opcode: got strobes=%b aluop=%b code=%b result=%0d expected 000000 00 0010 13", obs.strobes, obs.aluop, obs.code, obs.result);
        end
        void'(sb.pop_front());
    endtask

    task automatic test_back_to_back();
        out_t        obs, exp;
        logic [6:0]  ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h2B};
        logic [63:0] a, b;
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7)) : rnd64();
            b = ($urandom_range(0, 3) == 0) ? a : rnd64();
            @(negedge clk);
            drive(mk(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))), a, b, rnd64());
            @(posedge clk); #1;
            obs = sample();
            tests_run++;
            if (sb.size() == 0) begin failed++; $display("FAIL b2b_%0d: scoreboard empty", n); end
            else begin
                exp = sb.pop_front();
                if (obs !== exp) begin failed++; $display("FAIL b2b_%0d: instr=%h got %h expected %h", n, instr, obs, exp); end
            end
        end
    endtask

    task automatic test_async_reset();
        out_t obs, exp;
        @(negedge clk);
        drive(32'h002081B3, 64'd5, 64'd7, 64'd0);
        @(posedge clk); #1;
        void'(sb.pop_front());
        tests_run++;
        if (result !== 64'd12) begin failed++; $display("FAIL async_pre: got result=%0d expected 12", result); end
        @(negedge clk);
        drive(32'h402081B3, 64'd9, 64'd9, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        obs = sample();
        tests_run++;
        if (obs !== '0) begin failed++; $display("FAIL async_reset_immediate: got %h expected 0", obs); end
        sb.delete();
        @(posedge clk); #1;
        obs = sample();
        tests_run++;
        if (obs !== '0) begin failed++; $display("FAIL async_reset_discard: got %h expected 0", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h0000B103, 64'h40, 64'd0, 64'd16);
        @(posedge clk); #1;
        obs = sample();
        tests_run++;
        if (sb.size() == 0) begin failed++; $display("FAIL async_release: scoreboard empty"); end
        else begin
            exp = sb.pop_front();
            if (obs !== exp || result !== 64'h50) begin failed++; $display("FAIL async_release: got %h expected %h", obs, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_iarith();
        test_load_store();
        test_branch();
        test_overflow();
        test_unknown();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
